// File: rtl/alu_pkg.sv
// Shared ALU encodings for the decoder, ALU-control decoder and execute stage.
package alu_pkg;

  // ALU control codes driven by the ALU-control decoder
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b0011;
  localparam logic [3:0] ALU_DIV = 4'b0100;

  // Execute-stage state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // ALUOp from the main decoder
  localparam logic [1:0] ALUOP_LS    = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

endpackage

// File: rtl/alu_exec_unit_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, WIDTH cycles per op.
// done_o marks the cycle of the final step; quotient_o is valid in that cycle.
module seq_divider
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic             dbz_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  // One restoring step: shift in next dividend bit, subtract if it fits
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, div_q};
    quo_d  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    rem_d  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  end

  assign done_o     = busy_q && (cnt_q == CW'(1));
  assign quotient_o = quo_d;
  assign dbz_o      = (divisor_i == '0);

  // Load operands on start, then iterate until the counter expires
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(WIDTH);
      rem_q  <= '0;
      quo_q  <= dividend_i;
      div_q  <= divisor_i;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: AND/OR/ADD/SUB in one cycle, MUL/DIV iterative.
// ALU_MULDIV_EN enables MUL/DIV; otherwise codes 0011/0100 report illegal.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctr,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic             accept;

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  // Single-cycle datapath; anything else (incl. MUL/DIV here) is illegal
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_ctr)
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             is_div_q, is_div_d;
  logic             is_muldiv;
  logic             div_start, div_done, div_dbz;
  logic [WIDTH-1:0] div_quo;

  assign is_muldiv = (alu_ctr == ALU_MUL) || (alu_ctr == ALU_DIV);
  assign div_start = accept && (alu_ctr == ALU_DIV) && !div_dbz;

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i (op_a),
    .divisor_i  (op_b),
    .done_o     (div_done),
    .quotient_o (div_quo),
    .dbz_o      (div_dbz)
  );

  // Shift-add multiplier step, advanced only while BUSY
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (state_q == ST_BUSY) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end else if (accept) begin
      acc_d    = '0;
      mcand_d  = op_a;
      mplier_d = op_b;
    end
  end

  // Multiplier registers and shared step counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      is_div_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      is_div_q <= is_div_d;
    end
  end
`endif

  // Control FSM and result capture
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifdef ALU_MULDIV_EN
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_DONE;
          result_d  = alu_res;
          zero_d    = (alu_res == '0);
          illegal_d = alu_ill;
`ifdef ALU_MULDIV_EN
          if (is_muldiv) begin
            illegal_d = 1'b0;
            if ((alu_ctr == ALU_DIV) && div_dbz) begin
              result_d = '1;
              zero_d   = 1'b0;
            end else begin
              state_d  = ST_BUSY;
              cnt_d    = CW'(WIDTH);
              is_div_d = (alu_ctr == ALU_DIV);
            end
          end
`endif
        end
      end
`ifdef ALU_MULDIV_EN
      ST_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div_q) begin
          if (div_done) begin
            state_d  = ST_DONE;
            result_d = div_quo;
            zero_d   = (div_quo == '0);
          end
        end else if (cnt_q == CW'(1)) begin
          // acc_d already includes the final partial product
          state_d  = ST_DONE;
          result_d = acc_d;
          zero_d   = (acc_d == '0);
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH=32).
// Expectations follow ALU_MULDIV_EN the same way the RTL build does.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctr = 4'd0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int unsigned checks = 0;
  int unsigned errors = 0;

`ifdef ALU_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctr   (alu_ctr),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one op, wait for its accept edge, then scramble operands
  task automatic issue(input logic [3:0] ctr, input logic [31:0] a, input logic [31:0] b);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    alu_ctr  = ctr;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    alu_ctr  = 4'b0000;
  endtask

  // Edges from accept (accept edge = 1) until out_valid is seen
  task automatic wait_done(input string tag, input int unsigned exp_lat);
    int unsigned lat;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic expect_out(input string tag, input logic [31:0] r, input logic z, input logic ill);
    check({tag, "_result"},  result, r);
    check({tag, "_zero"},    {31'd0, zero}, {31'd0, z});
    check({tag, "_illegal"}, {31'd0, illegal}, {31'd0, ill});
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready_rise"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    // Reset
    @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    expect_out("rst", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD wraps into the sign bit
    issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    wait_done("add", 1);
    expect_out("add", 32'h8000_0000, 1'b0, 1'b0);
    consume("add");

    // SUB to zero under backpressure; a competing op is offered and ignored
    issue(4'b0110, 32'd5, 32'd5);
    wait_done("sub", 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      alu_ctr  = 4'b0001;
      op_a     = 32'h1234;
      op_b     = 32'h0;
      @(posedge clk);
      #1;
      check("sub_hold_valid", {31'd0, out_valid}, 32'd1);
      check("sub_hold_ready", {31'd0, in_ready}, 32'd0);
      expect_out("sub_hold", 32'h0, 1'b1, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    consume("sub");
    expect_out("sub_after", 32'h0, 1'b1, 1'b0);

    // MUL low word
    issue(4'b0011, 32'h0001_0000, 32'h0001_0001);
    if (MULDIV) begin
      wait_done("mul", 33);
      expect_out("mul", 32'h0001_0000, 1'b0, 1'b0);
    end else begin
      wait_done("mul_off", 1);
      expect_out("mul_off", 32'h0, 1'b1, 1'b1);
    end
    consume("mul");

    // DIV 100 / 7
    issue(4'b0100, 32'd100, 32'd7);
    if (MULDIV) begin
      wait_done("div", 33);
      expect_out("div", 32'd14, 1'b0, 1'b0);
    end else begin
      wait_done("div_off", 1);
      expect_out("div_off", 32'h0, 1'b1, 1'b1);
    end
    consume("div");

    // DIV by zero
    issue(4'b0100, 32'd9, 32'd0);
    wait_done("dbz", 1);
    if (MULDIV) expect_out("dbz", 32'hFFFF_FFFF, 1'b0, 1'b0);
    else        expect_out("dbz_off", 32'h0, 1'b1, 1'b1);
    consume("dbz");

    // Unsupported codes
    issue(4'b0111, 32'hDEAD_BEEF, 32'h1);
    wait_done("ill7", 1);
    expect_out("ill7", 32'h0, 1'b1, 1'b1);
    consume("ill7");
    issue(4'b1010, 32'h5, 32'h3);
    wait_done("illA", 1);
    expect_out("illA", 32'h0, 1'b1, 1'b1);
    consume("illA");

    // AND leaves a non-zero result so the reset check below is meaningful
    issue(4'b0000, 32'h0000_F0F0, 32'h0000_0FF0);
    wait_done("and", 1);
    expect_out("and", 32'h0000_00F0, 1'b0, 1'b0);
    consume("and");

    // Reset during the tenth BUSY cycle of a MUL
    issue(4'b0011, 32'h3, 32'h5);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    expect_out("midrst", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_ready_after", {31'd0, in_ready}, 32'd1);

    // OR after recovery
    issue(4'b0001, 32'h0000_00F0, 32'h0000_000F);
    wait_done("or", 1);
    expect_out("or", 32'h0000_00FF, 1'b0, 1'b0);
    consume("or");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute guard against a stuck run
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
